// File: rtl/sample_rearrange_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sample_rearrange_pkg
// Description : Shared coordinate-flag indices and diagonal-order stepping
//               for the sample (un)rearranger pair.
// Revision    : 1.0 - initial release
// ============================================================================
package sample_rearrange_pkg;

    localparam int unsigned COORD_WIDTH = 6;
    localparam int unsigned FIRST_X     = 0;
    localparam int unsigned FIRST_Y     = 1;
    localparam int unsigned FIRST_Z     = 2;
    localparam int unsigned LAST_X      = 3;
    localparam int unsigned LAST_Y      = 4;
    localparam int unsigned LAST_Z      = 5;

    // Next (z,t) in diagonal order; result packed as {z', t'}, 32 bits each.
    function automatic logic [63:0] diag_advance(
        input logic [31:0] z,
        input logic [31:0] t,
        input logic [31:0] zmax,
        input logic [31:0] tmax
    );
        logic [31:0] d_next;
        logic [31:0] z_n;
        logic [31:0] t_n;
        d_next = z + t + 32'd1;
        if (z != 32'd0 && t != tmax) begin
            z_n = z - 32'd1;
            t_n = t + 32'd1;
        end else if (d_next <= zmax) begin
            z_n = d_next;
            t_n = 32'd0;
        end else begin
            z_n = zmax;
            t_n = d_next - zmax;
        end
        return {z_n, t_n};
    endfunction

endpackage
`default_nettype wire

// File: rtl/sample_buffer_ram.sv
`default_nettype none
// ============================================================================
// Module      : sample_buffer_ram
// Description : Simple dual-port RAM, one write and one synchronous read
//               (1-cycle latency) per clock.
// Revision    : 1.0 - initial release
// ============================================================================
module sample_buffer_ram
    import sample_rearrange_pkg::*;
#(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  i_wr_en,
    input  logic [ADDR_WIDTH-1:0] i_wr_addr,
    input  logic [DATA_WIDTH-1:0] i_wr_data,
    input  logic                  i_rd_en,
    input  logic [ADDR_WIDTH-1:0] i_rd_addr,
    output logic [DATA_WIDTH-1:0] o_rd_data
);

    logic [DATA_WIDTH-1:0] r_mem [2**ADDR_WIDTH];

    always_ff @(posedge clk) begin
        if (i_wr_en) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end
        if (i_rd_en) begin
            o_rd_data <= r_mem[i_rd_addr];
        end
    end

endmodule
`default_nettype wire

// File: rtl/sample_unrearrange.sv
`default_nettype none
// ============================================================================
// Module      : sample_unrearrange
// Description : Reorders samples from diagonal (z,t) order back to BIP order
//               through an on-chip pixel buffer and a 2-entry output skid.
// Revision    : 1.0 - initial release
// ============================================================================
module sample_unrearrange
    import sample_rearrange_pkg::*;
#(
    parameter int MAX_X_WIDTH = 9,
    parameter int MAX_Y_WIDTH = 10,
    parameter int MAX_Z_WIDTH = 8,
    parameter int MAX_T_WIDTH = 19,
    parameter int DATA_WIDTH  = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [MAX_X_WIDTH-1:0] cfg_max_x,
    input  logic [MAX_Y_WIDTH-1:0] cfg_max_y,
    input  logic [MAX_Z_WIDTH-1:0] cfg_max_z,
    input  logic [MAX_T_WIDTH-1:0] cfg_max_t,
    input  logic [DATA_WIDTH-1:0]  axis_input_d,
    input  logic                   axis_input_valid,
    output logic                   axis_input_ready,
    output logic [DATA_WIDTH-1:0]  axis_output_d,
    output logic [5:0]             axis_output_coord,
    output logic                   axis_output_last,
    output logic                   axis_output_valid,
    input  logic                   axis_output_ready,
    output logic                   finished
);

    localparam int c_TW = MAX_T_WIDTH + 1;
    localparam int c_AW = 2 * MAX_Z_WIDTH;
    localparam int c_FW = DATA_WIDTH + COORD_WIDTH + 1;

    logic                   r_run;
    logic                   r_in_done;
    logic [MAX_Z_WIDTH-1:0] r_z_in;
    logic [MAX_T_WIDTH-1:0] r_t_in;
    logic [c_TW-1:0]        r_done_cnt;

    logic [MAX_Z_WIDTH-1:0] r_z_rd;
    logic [c_TW-1:0]        r_t_rd;
    logic [MAX_X_WIDTH-1:0] r_x_rd;
    logic [MAX_Y_WIDTH-1:0] r_y_rd;
    logic                   r_rd_valid;
    logic                   r_rd_last;
    logic [5:0]             r_rd_coord;
    logic [DATA_WIDTH-1:0]  w_ram_q;

    logic [1:0]             r_count;
    logic [c_FW-1:0]        r_slot0;
    logic [c_FW-1:0]        r_slot1;
    logic                   r_finished;

    logic [63:0]            w_adv;
    logic                   w_unused;
    logic [c_TW-1:0]        w_window;
    logic                   w_in_hs;
    logic                   w_pop;
    logic                   w_rd_issue;
    logic [5:0]             w_rd_flags;
    logic [c_FW-1:0]        w_push_word;

    assign w_adv    = diag_advance(32'(r_z_in), 32'(r_t_in), 32'(cfg_max_z), 32'(cfg_max_t));
    assign w_unused = ^{w_adv[63:32+MAX_Z_WIDTH], w_adv[31:MAX_T_WIDTH]};

    // The input may run at most Z pixels ahead of the pixel being read out.
    assign w_window         = {1'b0, r_t_in} - r_t_rd;
    assign axis_input_ready = r_run & ~r_in_done & (w_window <= c_TW'(cfg_max_z));
    assign w_in_hs          = axis_input_valid & axis_input_ready;

    assign w_pop      = axis_output_valid & axis_output_ready;
    assign w_rd_issue = (r_t_rd < r_done_cnt) &&
                        (({1'b0, r_count} + {2'b00, r_rd_valid} - {2'b00, w_pop}) <= 3'd1);

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_run      <= 1'b0;
            r_in_done  <= 1'b0;
            r_z_in     <= '0;
            r_t_in     <= '0;
            r_done_cnt <= '0;
        end else begin
            r_run <= 1'b1;
            if (w_in_hs) begin
                if (r_z_in == cfg_max_z) begin
                    r_done_cnt <= r_done_cnt + c_TW'(1);
                end
                if (r_z_in == cfg_max_z && r_t_in == cfg_max_t) begin
                    r_in_done <= 1'b1;
                end else begin
                    r_z_in <= w_adv[32 +: MAX_Z_WIDTH];
                    r_t_in <= w_adv[0 +: MAX_T_WIDTH];
                end
            end
        end
    end

    sample_buffer_ram #(
        .ADDR_WIDTH (c_AW),
        .DATA_WIDTH (DATA_WIDTH)
    ) u_ram (
        .clk       (clk),
        .i_wr_en   (w_in_hs),
        .i_wr_addr ({r_t_in[MAX_Z_WIDTH-1:0], r_z_in}),
        .i_wr_data (axis_input_d),
        .i_rd_en   (w_rd_issue),
        .i_rd_addr ({r_t_rd[MAX_Z_WIDTH-1:0], r_z_rd}),
        .o_rd_data (w_ram_q)
    );

    always_comb begin
        w_rd_flags          = '0;
        w_rd_flags[FIRST_X] = (r_x_rd == '0);
        w_rd_flags[FIRST_Y] = (r_y_rd == '0);
        w_rd_flags[FIRST_Z] = (r_z_rd == '0);
        w_rd_flags[LAST_X]  = (r_x_rd == cfg_max_x);
        w_rd_flags[LAST_Y]  = (r_y_rd == cfg_max_y);
        w_rd_flags[LAST_Z]  = (r_z_rd == cfg_max_z);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_z_rd     <= '0;
            r_t_rd     <= '0;
            r_x_rd     <= '0;
            r_y_rd     <= '0;
            r_rd_valid <= 1'b0;
            r_rd_last  <= 1'b0;
            r_rd_coord <= '0;
        end else begin
            r_rd_valid <= w_rd_issue;
            if (w_rd_issue) begin
                r_rd_coord <= w_rd_flags;
                r_rd_last  <= (r_z_rd == cfg_max_z) && (r_t_rd == {1'b0, cfg_max_t});
                if (r_z_rd == cfg_max_z) begin
                    r_z_rd <= '0;
                    r_t_rd <= r_t_rd + c_TW'(1);
                    if (r_x_rd == cfg_max_x) begin
                        r_x_rd <= '0;
                        r_y_rd <= (r_y_rd == cfg_max_y) ? '0 : r_y_rd + MAX_Y_WIDTH'(1);
                    end else begin
                        r_x_rd <= r_x_rd + MAX_X_WIDTH'(1);
                    end
                end else begin
                    r_z_rd <= r_z_rd + MAX_Z_WIDTH'(1);
                end
            end
        end
    end

    // Skid FIFO: slot0 is the output register, slot1 absorbs the in-flight read.
    assign w_push_word = {r_rd_last, r_rd_coord, w_ram_q};

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_count    <= '0;
            r_slot0    <= '0;
            r_slot1    <= '0;
            r_finished <= 1'b0;
        end else begin
            r_finished <= r_finished | (w_pop & axis_output_last);
            case ({r_rd_valid, w_pop})
                2'b10: begin
                    if (r_count == 2'd0) begin
                        r_slot0 <= w_push_word;
                    end else begin
                        r_slot1 <= w_push_word;
                    end
                    r_count <= r_count + 2'd1;
                end
                2'b01: begin
                    if (r_count == 2'd2) begin
                        r_slot0 <= r_slot1;
                    end
                    r_count <= r_count - 2'd1;
                end
                2'b11: begin
                    if (r_count == 2'd2) begin
                        r_slot0 <= r_slot1;
                        r_slot1 <= w_push_word;
                    end else begin
                        r_slot0 <= w_push_word;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign axis_output_valid = (r_count != 2'd0);
    assign axis_output_d     = r_slot0[DATA_WIDTH-1:0];
    assign axis_output_coord = r_slot0[DATA_WIDTH +: COORD_WIDTH];
    assign axis_output_last  = r_slot0[c_FW-1];
    assign finished          = r_finished;

endmodule
`default_nettype wire

// File: tb/tb_sample_unrearrange.sv
`default_nettype none
// ============================================================================
// Module      : tb_sample_unrearrange
// Description : Self-checking bench for sample_unrearrange.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sample_unrearrange;

    localparam int MXW = 9;
    localparam int MYW = 10;
    localparam int MZW = 8;
    localparam int MTW = 19;
    localparam int DW  = 16;

    logic           clk = 1'b0;
    logic           rst = 1'b0;
    logic [MXW-1:0] cfg_max_x = '0;
    logic [MYW-1:0] cfg_max_y = '0;
    logic [MZW-1:0] cfg_max_z = '0;
    logic [MTW-1:0] cfg_max_t = '0;
    logic [DW-1:0]  axis_input_d = '0;
    logic           axis_input_valid = 1'b0;
    logic           axis_input_ready;
    logic [DW-1:0]  axis_output_d;
    logic [5:0]     axis_output_coord;
    logic           axis_output_last;
    logic           axis_output_valid;
    logic           axis_output_ready = 1'b0;
    logic           finished;

    always #5 clk = ~clk;

    sample_unrearrange #(
        .MAX_X_WIDTH (MXW),
        .MAX_Y_WIDTH (MYW),
        .MAX_Z_WIDTH (MZW),
        .MAX_T_WIDTH (MTW),
        .DATA_WIDTH  (DW)
    ) dut (
        .clk               (clk),
        .rst               (rst),
        .cfg_max_x         (cfg_max_x),
        .cfg_max_y         (cfg_max_y),
        .cfg_max_z         (cfg_max_z),
        .cfg_max_t         (cfg_max_t),
        .axis_input_d      (axis_input_d),
        .axis_input_valid  (axis_input_valid),
        .axis_input_ready  (axis_input_ready),
        .axis_output_d     (axis_output_d),
        .axis_output_coord (axis_output_coord),
        .axis_output_last  (axis_output_last),
        .axis_output_valid (axis_output_valid),
        .axis_output_ready (axis_output_ready),
        .finished          (finished)
    );

    typedef struct {
        int         in_z;
        int         in_t;
        int         exp_d;
        logic [5:0] exp_coord;
        logic       exp_last;
    } vec_t;

    vec_t vec [12];

    int   total = 0;
    int   bad   = 0;
    int   vals[$];
    int   got_d[$];
    int   got_c[$];
    int   got_l[$];
    int   n_in, in_idx, accepted, cyc, hs_cyc, first_valid_cyc, lat_idx;
    int   in_idle, out_idle;
    int   cz, cx, cy, ct;
    logic out_hold, in_taken, fin_pending;

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d, required %0d", name, act, exp);
        end
    endtask

    task automatic clear_tb_state();
        in_idx = 0; accepted = 0; cyc = 0; hs_cyc = -1; first_valid_cyc = -1;
        in_taken = 1'b0; fin_pending = 1'b0;
        got_d.delete(); got_c.delete(); got_l.delete();
    endtask

    task automatic setup(input int z, input int x, input int y);
        cz = z; cx = x; cy = y; ct = (x + 1) * (y + 1) - 1;
        vals.delete();
        for (int d = 0; d <= cz + ct; d++) begin
            for (int zz = (d < cz) ? d : cz; zz >= ((d > ct) ? d - ct : 0); zz--) begin
                vals.push_back(zz * 64 + (d - zz));
            end
        end
        n_in    = vals.size();
        lat_idx = cz * (cz + 1) / 2;
        @(negedge clk);
        rst = 1'b0;
        axis_input_valid  = 1'b0;
        axis_output_ready = 1'b0;
        cfg_max_x = MXW'(cx);
        cfg_max_y = MYW'(cy);
        cfg_max_z = MZW'(cz);
        cfg_max_t = MTW'(ct);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        clear_tb_state();
    endtask

    task automatic step();
        @(negedge clk);
        cyc++;
        if (fin_pending) begin
            check("finished_after_last", int'(finished), 1);
            fin_pending = 1'b0;
        end
        if (in_taken) begin
            axis_input_valid = 1'b0;
            in_idx++;
            in_taken = 1'b0;
        end
        if (!axis_input_valid && in_idx < n_in && int'($urandom_range(99)) >= in_idle) begin
            axis_input_valid = 1'b1;
            axis_input_d     = DW'(vals[in_idx]);
        end
        axis_output_ready = !out_hold && (int'($urandom_range(99)) >= out_idle);
        #1;
        if (axis_input_valid && axis_input_ready) begin
            in_taken = 1'b1;
            accepted++;
            if (in_idx == lat_idx && hs_cyc < 0) hs_cyc = cyc;
        end
        if (axis_output_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
        if (axis_output_valid && axis_output_ready) begin
            got_d.push_back(int'(axis_output_d));
            got_c.push_back(int'(axis_output_coord));
            got_l.push_back(int'(axis_output_last));
            if (axis_output_last) begin
                check("finished_before_last", int'(finished), 0);
                fin_pending = 1'b1;
            end
        end
    endtask

    task automatic run_frame(input int max_cyc, input int stop_acc);
        for (int n = 0; n < max_cyc; n++) begin
            step();
            if (stop_acc > 0 && accepted >= stop_acc) return;
            if (stop_acc == 0 && got_d.size() >= n_in && !fin_pending) return;
        end
        total++;
        bad++;
        $display("FAIL frame_timeout: accepted=%0d outputs=%0d, required outputs %0d", accepted, got_d.size(), n_in);
    endtask

    task automatic compare_bip(input string tag);
        int nerr = 0;
        check({tag, "_count"}, got_d.size(), n_in);
        for (int k = 0; k < got_d.size() && k < n_in; k++) begin
            int         z, t, x, y, ed, el;
            logic [5:0] ec;
            z  = k % (cz + 1);
            t  = k / (cz + 1);
            x  = t % (cx + 1);
            y  = t / (cx + 1);
            ed = z * 64 + t;
            ec = {z == cz, y == cy, x == cx, z == 0, y == 0, x == 0};
            el = (k == n_in - 1) ? 1 : 0;
            total++;
            if (got_d[k] != ed || got_c[k] != int'(ec) || got_l[k] != el) begin
                bad++;
                if (nerr < 8)
                    $display("FAIL %s_sample[%0d]: got d=%0d coord=%0h last=%0d, required d=%0d coord=%0h last=%0d",
                             tag, k, got_d[k], got_c[k], got_l[k], ed, ec, el);
                nerr++;
            end
        end
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_in_ready"},  int'(axis_input_ready), 0);
        check({tag, "_out_valid"}, int'(axis_output_valid), 0);
        check({tag, "_out_last"},  int'(axis_output_last), 0);
        check({tag, "_out_coord"}, int'(axis_output_coord), 0);
        check({tag, "_out_d"},     int'(axis_output_d), 0);
        check({tag, "_finished"},  int'(finished), 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

    initial begin
        vec[0]  = '{0, 0,   0, 6'h17, 1'b0};
        vec[1]  = '{1, 0,  64, 6'h13, 1'b0};
        vec[2]  = '{0, 1, 128, 6'h13, 1'b0};
        vec[3]  = '{2, 0, 192, 6'h33, 1'b0};
        vec[4]  = '{1, 1,   1, 6'h16, 1'b0};
        vec[5]  = '{0, 2,  65, 6'h12, 1'b0};
        vec[6]  = '{3, 0, 129, 6'h12, 1'b0};
        vec[7]  = '{2, 1, 193, 6'h32, 1'b0};
        vec[8]  = '{1, 2,   2, 6'h1E, 1'b0};
        vec[9]  = '{3, 1,  66, 6'h1A, 1'b0};
        vec[10] = '{2, 2, 130, 6'h1A, 1'b0};
        vec[11] = '{3, 2, 194, 6'h3A, 1'b1};
        in_idle = 0; out_idle = 0; out_hold = 1'b0;

        // Full frame, both sides always ready
        setup(7, 7, 7);
        check_reset_values("reset");
        run_frame(5000, 0);
        compare_bip("stream");
        check("latency_first_valid", first_valid_cyc - hs_cyc, 3);

        // Output backpressure stalls the input window
        setup(7, 7, 7);
        out_hold = 1'b1;
        repeat (100) step();
        check("stall_accepted", accepted, 43);
        check("stall_in_ready", int'(axis_input_ready), 0);
        check("stall_out_valid", int'(axis_output_valid), 1);
        check("stall_out_d", int'(axis_output_d), 0);
        out_hold = 1'b0;
        run_frame(5000, 0);
        compare_bip("stall");

        // Random idle cycles on both sides
        setup(7, 7, 7);
        in_idle = 30; out_idle = 30;
        run_frame(8000, 0);
        compare_bip("random");
        in_idle = 0; out_idle = 0;

        // Z > T, table-driven
        setup(3, 2, 0);
        vals.delete();
        for (int k = 0; k < 12; k++) vals.push_back(vec[k].in_z * 64 + vec[k].in_t);
        n_in = 12;
        run_frame(500, 0);
        check("small_count", got_d.size(), 12);
        for (int k = 0; k < 12 && k < got_d.size(); k++) begin
            total++;
            if (got_d[k] != vec[k].exp_d || got_c[k] != int'(vec[k].exp_coord) ||
                got_l[k] != int'(vec[k].exp_last)) begin
                bad++;
                $display("FAIL small_vec[%0d]: got d=%0d coord=%0h last=%0d, required d=%0d coord=%0h last=%0d",
                         k, got_d[k], got_c[k], got_l[k], vec[k].exp_d, vec[k].exp_coord, vec[k].exp_last);
            end
        end

        // Z = 0 pass-through
        setup(0, 3, 3);
        run_frame(500, 0);
        compare_bip("passthru");
        check("passthru_latency", first_valid_cyc - hs_cyc, 3);

        // One-cycle reset mid-frame, then a fresh frame
        setup(7, 7, 7);
        run_frame(5000, 100);
        @(negedge clk);
        rst = 1'b0;
        axis_input_valid  = 1'b0;
        axis_output_ready = 1'b1;
        @(negedge clk);
        #1;
        check_reset_values("midrst");
        rst = 1'b1;
        clear_tb_state();
        run_frame(5000, 0);
        compare_bip("after_reset");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
